concat_mac_seq: RTL and testbench

CONCAT_MAC_SEQ -- requirements
Module: concat_mac_seq

---
 rtl/concat_mac_seq.sv | 165 ++++++++++++++++
 tb/tb_concat_mac_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/concat_mac_seq.sv
// rtl/concat_mac_seq.sv - sequential concat dot-product MAC: bias + sum(w*d)>>>FRACT, optional saturation via CONCAT_MAC_SAT_EN
module concat_mac_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int N_X         = 4,
  parameter int N_H         = 4,
  parameter int ACC_WIDTH   = 2 * DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_w,
  input  logic signed [DATA_WIDTH-1:0] in_d,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int N_TERMS = N_X + N_H;
  localparam int CNT_W   = $clog2(N_TERMS + 1);
  localparam int PROD_W  = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]       cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]  bias_q, bias_d;
  logic signed [DATA_WIDTH-1:0]  out_q, out_d;
  logic                          out_valid_q, out_valid_d;

  logic                          accept;
  logic                          last_term;
  logic                          handshake;
  logic signed [PROD_W-1:0]      prod;
  logic signed [PROD_W-1:0]      prod_sh;
  logic signed [ACC_WIDTH-1:0]   term;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic signed [DATA_WIDTH-1:0]  fmt_res;

`ifdef CONCAT_MAC_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX_D = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN_D = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0]  SAT_MAX   = ACC_WIDTH'(SAT_MAX_D);
  localparam logic signed [ACC_WIDTH-1:0]  SAT_MIN   = ACC_WIDTH'(SAT_MIN_D);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start only counts in IDLE, last accepted term ends ACC, handshake ends DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)                 state_d = S_ACC;
      S_ACC:   if (accept && last_term)   state_d = S_DONE;
      S_DONE:  if (handshake)             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    in_ready  = (state_q == S_ACC);
    busy      = (state_q != S_IDLE);
    out       = out_q;
    out_valid = out_valid_q;
  end

  // Term product: full-width signed multiply, arithmetic shift, then resize to the accumulator
  always_comb begin
    accept    = in_valid && (state_q == S_ACC);
    last_term = (cnt_q == CNT_W'(N_TERMS - 1));
    handshake = out_valid_q && out_ready;
    prod      = PROD_W'(in_w) * PROD_W'(in_d);
    prod_sh   = prod >>> FRACT_WIDTH;
    term      = ACC_WIDTH'(prod_sh);
    acc_next  = acc_q + term;
    sum       = acc_next + ACC_WIDTH'(bias_q);
  end

  // Result formatting: clamp to the data range or keep the low bits
  always_comb begin
`ifdef CONCAT_MAC_SAT_EN
    if (sum > SAT_MAX) begin
      fmt_res = SAT_MAX_D;
    end else if (sum < SAT_MIN) begin
      fmt_res = SAT_MIN_D;
    end else begin
      fmt_res = DATA_WIDTH'(sum);
    end
`else
    fmt_res = DATA_WIDTH'(sum);
`endif
  end

  // Datapath next values: clear on start, accumulate on accept, load result on the last term
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bias_d      = bias_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d  = '0;
          cnt_d  = '0;
          bias_d = b;
        end
      end
      S_ACC: begin
        if (accept) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_term) begin
            out_d       = fmt_res;
            out_valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (handshake) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset drops any partial transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      bias_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bias_q      <= bias_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_concat_mac_seq.sv
// tb/tb_concat_mac_seq.sv - directed scoreboard bench for concat_mac_seq
module tb_concat_mac_seq;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [15:0] b;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_w;
  logic signed [15:0] in_d;
  logic signed [15:0] out;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_acc;
  int exp_bias;
  int busy_drops;
  int exp_q[$];

  concat_mac_seq #(
    .DATA_WIDTH(16), .FRACT_WIDTH(8), .N_X(2), .N_H(2), .ACC_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_d(in_d),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int term_of(int w, int d);
    int p;
    p = w * d;
    return p >>> 8;
  endfunction

  function automatic int fmt(int s);
`ifdef CONCAT_MAC_SAT_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    shortint t;
    t = shortint'(s);
    return int'(t);
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int bias);
    start = 1'b1;
    b = 16'(bias);
    @(negedge clk);
    start = 1'b0;
    exp_acc = 0;
    exp_bias = bias;
  endtask

  task automatic send_term(input int w, input int d, input int stall);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
      if (!busy) busy_drops++;
    end
    in_valid = 1'b1;
    in_w = 16'(w);
    in_d = 16'(d);
    @(negedge clk);
    in_valid = 1'b0;
    exp_acc = exp_acc + term_of(w, d);
  endtask

  task automatic push_expected();
    exp_q.push_back(fmt(exp_acc + exp_bias));
  endtask

  task automatic collect(input string tag);
    int waited;
    int e;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 0, 1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, int'(out), e);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, int'(out_valid), 0);
      check({tag, "_idle"}, int'(busy), 0);
      check({tag, "_out_hold"}, int'(out), e);
    end
  endtask

  initial begin
    int held_out;
    int changes;
    rst = 1'b1; start = 1'b0; b = '0; in_valid = 1'b0;
    in_w = '0; in_d = '0; out_ready = 1'b0;
    busy_drops = 0; exp_acc = 0; exp_bias = 0;
    @(negedge clk);
    check("rst_out", int'(out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic back-to-back transaction with latency check
    do_start(256);
    check("acc_busy", int'(busy), 1);
    check("acc_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 3; i++) send_term(256, 512, 0);
    check("basic_early_valid", int'(out_valid), 0);
    send_term(256, 512, 0);
    push_expected();
    check("basic_latency", int'(out_valid), 1);
    collect("basic");

    // Mixed signs with stalls between terms
    busy_drops = 0;
    do_start(0);
    send_term(-256, 256, 0);
    send_term(256, 256, 3);
    send_term(128, -512, 3);
    send_term(512, 128, 3);
    push_expected();
    check("stall_busy_drops", busy_drops, 0);
    collect("signs_stalls");

    // Overflow: saturate or wrap depending on build
    do_start(0);
    for (int i = 0; i < 4; i++) send_term(32767, 32767, 0);
    push_expected();
    collect("overflow");

    // Backpressure: hold result, ignore start pulses, ignore start on handshake
    do_start(256);
    for (int i = 0; i < 4; i++) send_term(256, 512, 0);
    push_expected();
    held_out = int'(out);
    changes = 0;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      @(negedge clk);
      if (int'(out) != held_out || !out_valid) changes++;
    end
    start = 1'b0;
    check("bp_stable", changes, 0);
    check("bp_out", int'(out), exp_q[0]);
    void'(exp_q.pop_front());
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    check("bp_drop", int'(out_valid), 0);
    check("bp_start_on_handshake_ignored", int'(busy), 0);
    // In_valid while idle must have no effect
    in_valid = 1'b1; in_w = 16'sd1000; in_d = 16'sd1000;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    do_start(-100);
    send_term(300, 200, 0);
    send_term(-700, 50, 1);
    send_term(1000, 1000, 0);
    send_term(-5, 9, 2);
    push_expected();
    collect("after_bp");

    // Reset mid-transaction abandons it
    do_start(256);
    send_term(256, 512, 0);
    send_term(256, 512, 0);
    rst = 1'b1;
    #1;
    check("midrst_out", int'(out), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(256);
    for (int i = 0; i < 4; i++) send_term(256, 512, 0);
    push_expected();
    collect("post_reset");
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
